// File: rtl/ovl_one_cold_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ovl_sched_pkg
// Description : Shared types and helpers for the one-cold scheduler slice.
//               Holds the scheduler state encoding, the INACTIVE encodings
//               and the one-cold legality check used on the granted vector.
// Revision    : 1.0 - initial release
// ============================================================================
package ovl_sched_pkg;

    // Scheduler state: IDLE holds no verdict, HOLD presents one on rsp_*.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_e;

    // Extra legal value selected by the INACTIVE parameter.
    localparam int OVL_INACT_NONE  = 0;
    localparam int OVL_INACT_ZEROS = 1;
    localparam int OVL_INACT_ONES  = 2;

    // Widest vector the legality helper accepts.
    localparam int OVL_MAX_W = 64;

    // Legal when exactly one of the low 'width' bits is 0, or when the vector
    // equals the extra value that 'inactive' allows. Bits at or above 'width'
    // are ignored, so callers may zero-extend freely.
    function automatic logic onecold_ok(
        input logic [OVL_MAX_W-1:0] vec,
        input int                   inactive,
        input int                   width = OVL_MAX_W
    );
        int zeros;
        zeros = 0;
        for (int i = 0; i < OVL_MAX_W; i++) begin
            if ((i < width) && !vec[i]) begin
                zeros++;
            end
        end
        return (zeros == 1)
            || ((inactive == OVL_INACT_ZEROS) && (zeros == width))
            || ((inactive == OVL_INACT_ONES)  && (zeros == 0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ovl_one_cold_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : ovl_one_cold_sched_if
// Description : Requester/verdict handshake bundle of the one-cold scheduler.
//               master : stimulus side (drives req_valid/req_expr/rsp_ready)
//               slave  : scheduler side (drives req_ready and rsp_*)
//               req_expr carries requester i at bits [i*WIDTH +: WIDTH].
// Revision    : 1.0 - initial release
// ============================================================================
interface ovl_one_cold_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
);
    localparam int c_ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_expr;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [c_ID_W-1:0]        rsp_id;
    logic                     rsp_fire;
    logic                     rsp_xz;

    modport master (
        output req_valid, req_expr, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_fire, rsp_xz
    );

    modport slave (
        input  req_valid, req_expr, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_fire, rsp_xz
    );
endinterface
`default_nettype wire

// File: rtl/ovl_one_cold_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ovl_rr_arbiter
// Description : Round-robin arbiter. Combinational one-hot grant searching
//               from last_grant+1 with wrap-around; last_grant advances only
//               when the grant is actually taken (advance=1).
// Ports       : clk, rst        - clock, synchronous active-high reset
//               req             - request vector
//               advance         - grant is consumed this cycle
//               grant/grant_id  - one-hot winner and its index
//               grant_any       - some request is pending
// Revision    : 1.0 - initial release
// ============================================================================
module ovl_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic [NUM_REQ-1:0]         req,
    input  wire logic                       advance,
    output logic      [NUM_REQ-1:0]         grant,
    output logic      [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                            grant_any
);
    localparam int                c_ID_W     = $clog2(NUM_REQ);
    localparam logic [c_ID_W-1:0] c_LAST_RST = c_ID_W'(NUM_REQ - 1);

    logic [c_ID_W-1:0] r_last;
    logic [c_ID_W-1:0] w_hi_id;
    logic [c_ID_W-1:0] w_lo_id;
    logic              w_hi_found;
    logic              w_lo_found;

    // Two priority passes avoid a variable modulo: the first finds the lowest
    // requester above r_last, the second the lowest overall (the wrap case).
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_id    = '0;
        w_lo_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !w_hi_found && (c_ID_W'(i) > r_last)) begin
                w_hi_found = 1'b1;
                w_hi_id    = c_ID_W'(i);
            end
            if (req[i] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_id    = c_ID_W'(i);
            end
        end
    end

    always_comb begin
        grant_any = w_hi_found | w_lo_found;
        grant_id  = w_hi_found ? w_hi_id : w_lo_id;
        grant     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = grant_any && (grant_id == c_ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= c_LAST_RST;
        end else if (advance && grant_any) begin
            r_last <= grant_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ovl_one_cold_sched.sv
`default_nettype none
// ============================================================================
// Module      : ovl_one_cold_sched
// Description : Shares one registered one-cold checker among NUM_REQ
//               requesters. One requester is granted per cycle (round-robin),
//               its verdict appears on rsp_* the next cycle tagged with the
//               requester id. Accepted failing verdicts bump a saturating
//               error counter and a per-requester sticky flag.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               enable        - allows new grants (held verdict still drains)
//               bus (slave)   - req_valid/req_ready/req_expr, rsp_* handshake
//               clr_sticky    - clears err_cnt and fire_sticky (wins over set)
//               err_cnt       - saturating count of accepted failing verdicts
//               fire_sticky   - per-requester sticky fail flag
// Config      : OVL_XCHECK_EN - when defined, X/Z in the granted vector
//               raises rsp_xz and rsp_fire; otherwise rsp_xz is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module ovl_one_cold_sched
    import ovl_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 4,
    parameter int INACTIVE = 0,
    parameter int CNT_W    = 8
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                enable,
    ovl_one_cold_sched_if.slave      bus,
    input  wire logic                clr_sticky,
    output logic      [CNT_W-1:0]    err_cnt,
    output logic      [NUM_REQ-1:0]  fire_sticky
);
    localparam int c_ID_W = $clog2(NUM_REQ);

    sched_state_e        r_state;
    logic                r_rsp_valid;
    logic [c_ID_W-1:0]   r_rsp_id;
    logic                r_rsp_fire;
    logic                r_rsp_xz;
    logic [CNT_W-1:0]    r_err_cnt;
    logic [NUM_REQ-1:0]  r_sticky;

    logic                w_can_grant;
    logic                w_take;
    logic                w_accept;
    logic [NUM_REQ-1:0]  w_grant;
    logic [c_ID_W-1:0]   w_gid;
    logic                w_any;
    logic [WIDTH-1:0]    w_vec;
    logic [OVL_MAX_W-1:0] w_vec_ext;
    logic                w_ok;
    logic                w_xz;
    logic                w_fire;

    // A new grant may replace the held verdict in the same cycle it is
    // accepted, which keeps one verdict per cycle under rsp_ready=1.
    assign w_can_grant = enable && !rst && ((r_state == IDLE) || bus.rsp_ready);
    assign w_take      = w_can_grant && w_any;
    assign w_accept    = r_rsp_valid && bus.rsp_ready;

    ovl_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .advance   (w_can_grant),
        .grant     (w_grant),
        .grant_id  (w_gid),
        .grant_any (w_any)
    );

    assign bus.req_ready = w_can_grant ? w_grant : '0;

    // Select the winner's vector from the flat bus.
    always_comb begin
        w_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_vec = bus.req_expr[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_vec_ext           = '0;
        w_vec_ext[WIDTH-1:0] = w_vec;
        w_ok                = onecold_ok(w_vec_ext, INACTIVE, WIDTH);
`ifdef OVL_XCHECK_EN
        w_xz                = ((^w_vec) === 1'bx);
`else
        w_xz                = 1'b0;
`endif
        w_fire              = !w_ok || w_xz;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_fire  <= 1'b0;
            r_rsp_xz    <= 1'b0;
            r_err_cnt   <= '0;
            r_sticky    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_state     <= HOLD;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= w_gid;
                        r_rsp_fire  <= w_fire;
                        r_rsp_xz    <= w_xz;
                    end
                end
                HOLD: begin
                    if (w_take) begin
                        r_rsp_id    <= w_gid;
                        r_rsp_fire  <= w_fire;
                        r_rsp_xz    <= w_xz;
                    end else if (bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase

            if (clr_sticky) begin
                r_err_cnt <= '0;
                r_sticky  <= '0;
            end else if (w_accept && r_rsp_fire) begin
                if (r_err_cnt != {CNT_W{1'b1}}) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                r_sticky[r_rsp_id] <= 1'b1;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_fire  = r_rsp_fire;
    assign bus.rsp_xz    = r_rsp_xz;
    assign err_cnt       = r_err_cnt;
    assign fire_sticky   = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_ovl_one_cold_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ovl_one_cold_sched
// Description : Self-checking bench for ovl_one_cold_sched. A directed vector
//               table covers reset, ordering, backpressure, enable and clear;
//               a randomized phase is compared against a behavioural model; a
//               second instance (INACTIVE=2, CNT_W=2) covers saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ovl_one_cold_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] err;
    logic [3:0] sticky;

    logic       en_b  = 1'b1;
    logic       clr_b = 1'b0;
    logic [1:0] err_b;
    logic [3:0] sticky_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ovl_one_cold_sched_if #(.NUM_REQ(4), .WIDTH(4)) bus ();
    ovl_one_cold_sched_if #(.NUM_REQ(4), .WIDTH(4)) bus_b ();

    ovl_one_cold_sched #(.NUM_REQ(4), .WIDTH(4), .INACTIVE(0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .enable(en), .bus(bus),
        .clr_sticky(clr), .err_cnt(err), .fire_sticky(sticky)
    );

    ovl_one_cold_sched #(.NUM_REQ(4), .WIDTH(4), .INACTIVE(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .bus(bus_b),
        .clr_sticky(clr_b), .err_cnt(err_b), .fire_sticky(sticky_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [3:0] v, input int inact);
        int z;
        z = 4 - $countones(v);
        return (z == 1) || (inact == 1 && z == 4) || (inact == 2 && z == 0);
    endfunction

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        rdy;
        logic        clr;
        logic [3:0]  valid;
        logic [15:0] expr;
        logic [3:0]  e_ready;
        logic        e_rv;
        logic [1:0]  e_id;
        logic        e_fire;
        logic [7:0]  e_err;
        logic [3:0]  e_sticky;
    } vec_t;

    vec_t tbl[26];

    // Random-phase model state.
    bit         m_have;
    int         m_id;
    bit         m_fire;
    int         m_last;
    int         m_err;
    bit [3:0]   m_st;
    bit [3:0]   pend;
    logic [3:0] ex[4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst en rdy clr valid    expr     ready   rv id    fi err   sticky
        tbl[0]  = '{1'b0,1'b1,1'b1,1'b0,4'b0100,16'h0D00,4'b0100,1'b0,2'd0,1'b0,8'd0,4'b0000};
        tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,4'b0000,16'h0D00,4'b0000,1'b1,2'd2,1'b0,8'd0,4'b0000};
        tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,4'b0000,16'h0000,4'b0000,1'b0,2'd0,1'b0,8'd0,4'b0000};
        tbl[3]  = '{1'b0,1'b1,1'b1,1'b0,4'b1111,16'hB09E,4'b0001,1'b0,2'd0,1'b0,8'd0,4'b0000};
        tbl[4]  = '{1'b0,1'b1,1'b1,1'b0,4'b1110,16'hB09E,4'b0010,1'b1,2'd0,1'b0,8'd0,4'b0000};
        tbl[5]  = '{1'b0,1'b1,1'b1,1'b0,4'b1100,16'hB09E,4'b0100,1'b1,2'd1,1'b1,8'd0,4'b0000};
        tbl[6]  = '{1'b0,1'b1,1'b1,1'b0,4'b1000,16'hB09E,4'b1000,1'b1,2'd2,1'b1,8'd1,4'b0010};
        tbl[7]  = '{1'b0,1'b1,1'b1,1'b0,4'b0000,16'hB09E,4'b0000,1'b1,2'd3,1'b0,8'd2,4'b0110};
        tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,4'b0000,16'h0000,4'b0000,1'b0,2'd3,1'b0,8'd2,4'b0110};
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,4'b0001,16'h0007,4'b0001,1'b0,2'd0,1'b0,8'd2,4'b0110};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b0,4'b0010,16'h00F0,4'b0000,1'b1,2'd0,1'b0,8'd2,4'b0110};
        tbl[11] = '{1'b0,1'b1,1'b0,1'b0,4'b0010,16'h00F0,4'b0000,1'b1,2'd0,1'b0,8'd2,4'b0110};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b0,4'b0010,16'h00F0,4'b0000,1'b1,2'd0,1'b0,8'd2,4'b0110};
        tbl[13] = '{1'b0,1'b1,1'b1,1'b0,4'b0010,16'h00F0,4'b0010,1'b1,2'd0,1'b0,8'd2,4'b0110};
        tbl[14] = '{1'b0,1'b1,1'b1,1'b0,4'b0000,16'h0000,4'b0000,1'b1,2'd1,1'b1,8'd2,4'b0110};
        tbl[15] = '{1'b0,1'b1,1'b1,1'b0,4'b0000,16'h0000,4'b0000,1'b0,2'd1,1'b1,8'd3,4'b0110};
        tbl[16] = '{1'b0,1'b1,1'b1,1'b0,4'b0100,16'h0B00,4'b0100,1'b0,2'd0,1'b0,8'd3,4'b0110};
        tbl[17] = '{1'b0,1'b0,1'b1,1'b0,4'b1000,16'h0000,4'b0000,1'b1,2'd2,1'b0,8'd3,4'b0110};
        tbl[18] = '{1'b0,1'b0,1'b1,1'b0,4'b1000,16'h0000,4'b0000,1'b0,2'd2,1'b0,8'd3,4'b0110};
        tbl[19] = '{1'b0,1'b1,1'b1,1'b0,4'b1000,16'h0000,4'b1000,1'b0,2'd2,1'b0,8'd3,4'b0110};
        tbl[20] = '{1'b0,1'b1,1'b1,1'b0,4'b0000,16'h0000,4'b0000,1'b1,2'd3,1'b1,8'd3,4'b0110};
        tbl[21] = '{1'b0,1'b1,1'b1,1'b1,4'b0000,16'h0000,4'b0000,1'b0,2'd3,1'b1,8'd4,4'b1110};
        tbl[22] = '{1'b0,1'b1,1'b1,1'b0,4'b0000,16'h0000,4'b0000,1'b0,2'd3,1'b1,8'd0,4'b0000};
        tbl[23] = '{1'b0,1'b1,1'b1,1'b0,4'b0001,16'h0008,4'b0001,1'b0,2'd0,1'b0,8'd0,4'b0000};
        tbl[24] = '{1'b1,1'b1,1'b1,1'b0,4'b0000,16'h0000,4'b0000,1'b1,2'd0,1'b1,8'd0,4'b0000};
        tbl[25] = '{1'b0,1'b1,1'b1,1'b0,4'b0000,16'h0000,4'b0000,1'b0,2'd0,1'b0,8'd0,4'b0000};

        bus.req_valid   = 4'b1111;
        bus.req_expr    = '0;
        bus.rsp_ready   = 1'b1;
        bus_b.req_valid = 4'b0000;
        bus_b.req_expr  = '0;
        bus_b.rsp_ready = 1'b1;

        // Reset held for five clocks with every requester valid.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("reset_req_ready", 32'(bus.req_ready), 32'h0);
            chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            chk("reset_err_cnt", 32'(err), 32'h0);
        end
        chk("reset_sticky", 32'(sticky), 32'h0);

        // Directed table.
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            rst           = tbl[k].rst;
            en            = tbl[k].en;
            bus.rsp_ready = tbl[k].rdy;
            clr           = tbl[k].clr;
            bus.req_valid = tbl[k].valid;
            bus.req_expr  = tbl[k].expr;
            #1;
            chk($sformatf("v%0d_req_ready", k), 32'(bus.req_ready), 32'(tbl[k].e_ready));
            chk($sformatf("v%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'(tbl[k].e_rv));
            if (tbl[k].e_rv) begin
                chk($sformatf("v%0d_rsp_id", k), 32'(bus.rsp_id), 32'(tbl[k].e_id));
                chk($sformatf("v%0d_rsp_fire", k), 32'(bus.rsp_fire), 32'(tbl[k].e_fire));
                chk($sformatf("v%0d_rsp_xz", k), 32'(bus.rsp_xz), 32'h0);
            end
            chk($sformatf("v%0d_err_cnt", k), 32'(err), 32'(tbl[k].e_err));
            chk($sformatf("v%0d_sticky", k), 32'(sticky), 32'(tbl[k].e_sticky));
        end

        // Randomized phase against the behavioural model.
        @(negedge clk);
        rst = 1'b1; clr = 1'b0; en = 1'b1; bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        m_have = 0; m_last = 3; m_err = 0; m_st = '0; pend = '0;
        for (int i = 0; i < 4; i++) ex[i] = 4'hF;
        for (int c = 0; c < 400; c++) begin
            int  win;
            bit  acc;
            logic [3:0] exp_ready;
            if (c != 0) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    if ($urandom_range(0, 1) == 1) ex[i] = ~(4'b0001 << $urandom_range(0, 3));
                    else                            ex[i] = 4'($urandom);
                end
            end
            en            = ($urandom_range(0, 7) != 0);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            clr           = ($urandom_range(0, 31) == 0);
            bus.req_valid = pend;
            bus.req_expr  = {ex[3], ex[2], ex[1], ex[0]};
            #1;
            win = -1;
            if (en && (!m_have || bus.rsp_ready)) begin
                for (int o = 1; o <= 4; o++) begin
                    int j;
                    j = (m_last + o) % 4;
                    if (win < 0 && pend[j]) win = j;
                end
            end
            exp_ready = (win >= 0) ? 4'(1 << win) : 4'b0000;
            chk("rnd_req_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(m_have));
            if (m_have) begin
                chk("rnd_rsp_id", 32'(bus.rsp_id), 32'(m_id));
                chk("rnd_rsp_fire", 32'(bus.rsp_fire), 32'(m_fire));
            end
            chk("rnd_err_cnt", 32'(err), 32'(m_err));
            chk("rnd_sticky", 32'(sticky), 32'(m_st));
            acc = m_have && bus.rsp_ready;
            if (clr) begin
                m_err = 0;
                m_st  = '0;
            end else if (acc && m_fire) begin
                if (m_err < 255) m_err++;
                m_st[m_id] = 1'b1;
            end
            if (win >= 0) begin
                m_have    = 1;
                m_id      = win;
                m_fire    = !legal(ex[win], 0);
                m_last    = win;
                pend[win] = 1'b0;
            end else if (acc) begin
                m_have = 0;
            end
        end
        @(negedge clk);
        bus.req_valid = '0; clr = 1'b0;

        // Second instance: INACTIVE=2 legal all-ones, then saturation at 3.
        bus_b.req_valid = 4'b0001;
        bus_b.req_expr  = 16'h000F;
        #1;
        chk("b_first_ready", 32'(bus_b.req_ready), 32'h1);
        @(negedge clk);
        bus_b.req_expr = 16'h0000;
        #1;
        chk("b_ones_rsp_valid", 32'(bus_b.rsp_valid), 32'h1);
        chk("b_ones_fire", 32'(bus_b.rsp_fire), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("b_zeros_fire", 32'(bus_b.rsp_fire), 32'h1);
        end
        @(negedge clk);
        bus_b.req_valid = 4'b0000;
        #1;
        chk("b_last_fire", 32'(bus_b.rsp_fire), 32'h1);
        @(negedge clk);
        #1;
        chk("b_err_saturated", 32'(err_b), 32'h3);
        chk("b_sticky", 32'(sticky_b), 32'h1);
        @(negedge clk);
        clr_b = 1'b1;
        #1;
        chk("b_err_before_clr", 32'(err_b), 32'h3);
        @(negedge clk);
        clr_b = 1'b0;
        #1;
        chk("b_err_cleared", 32'(err_b), 32'h0);
        chk("b_sticky_cleared", 32'(sticky_b), 32'h0);
`ifdef OVL_XCHECK_EN
        @(negedge clk);
        bus_b.req_valid = 4'b0001;
        bus_b.req_expr  = 16'b0000_0000_0000_0x11;
        @(negedge clk);
        bus_b.req_valid = 4'b0000;
        #1;
        chk("b_xz_flag", 32'(bus_b.rsp_xz), 32'h1);
        chk("b_xz_fire", 32'(bus_b.rsp_fire), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
